// File: rtl/rr_pkg.sv
// Shared types and defaults for the round-robin grant encoder.
package rr_pkg;

  typedef enum logic {IDLE, GRANT} state_t;

  localparam int RR_N = 3;

endpackage

// File: rtl/onehot_decoder.sv
// N-to-2**N one-hot decoder driven by the grant index.
module onehot_decoder #(
  parameter int N = 3
) (
  input  logic [N-1:0]    sel,
  output logic [2**N-1:0] dec
);

  always_comb begin
    dec      = '0;
    dec[sel] = 1'b1;
  end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request scanning upward from ptr with wrap.
// Optional one-slot mask removes the just-acknowledged winner from this decision.
module rr_pick
  import rr_pkg::*;
#(
  parameter int N = RR_N
) (
  input  logic [2**N-1:0] req,
  input  logic [N-1:0]    ptr,
  input  logic [N-1:0]    mask_idx,
  input  logic            mask_en,
  output logic [N-1:0]    pick_idx,
  output logic            pick_any
);

  localparam int R = 2**N;

  logic [R-1:0]   req_m;
  logic [2*R-1:0] dbl;
  logic [R-1:0]   rot;
  logic [N-1:0]   off;

  always_comb begin
    req_m = req;
    if (mask_en) begin
      req_m[mask_idx] = 1'b0;
    end
    // Doubling the vector lets a plain part-select perform the rotate by ptr.
    dbl      = {req_m, req_m};
    rot      = dbl[ptr +: R];
    off      = '0;
    pick_any = 1'b0;
    for (int i = R - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off      = N'(i);
        pick_any = 1'b1;
      end
    end
    pick_idx = ptr + off;
  end

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter over 2**N requesters; registered binary grant, 1-cycle req->grant and ack->grant.
// Grant is held until ack; back-to-back grants with no bubble while requests remain pending.
module rr_grant_encoder
  import rr_pkg::*;
#(
  parameter int N = RR_N
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2**N-1:0] req,
  input  logic            ack,
  output logic [N-1:0]    grant_idx,
  output logic            grant_valid
);

  state_t       state_q, state_d;
  logic [N-1:0] ptr_q, ptr_d;
  logic [N-1:0] idx_d;
  logic         vld_d;

  logic         acked;
  logic [N-1:0] ptr_next;
  logic [N-1:0] pick_ptr;
  logic [N-1:0] pick_idx;
  logic         pick_any;

  // On ack the pick already uses the advanced pointer so the next grant lands with no bubble.
  assign acked    = (state_q == GRANT) && ack;
  assign ptr_next = grant_idx + N'(1);
  assign pick_ptr = acked ? ptr_next : ptr_q;

  rr_pick #(.N(N)) u_pick (
    .req      (req),
    .ptr      (pick_ptr),
    .mask_idx (grant_idx),
    .mask_en  (acked),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = grant_idx;
    vld_d   = grant_valid;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          idx_d   = pick_idx;
          vld_d   = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (ack) begin
          ptr_d = ptr_next;
          if (pick_any) begin
            idx_d = pick_idx;
          end else begin
            vld_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_idx   <= idx_d;
      grant_valid <= vld_d;
    end
  end

  a_vld_tracks_state: assert property (@(posedge clk) disable iff (reset)
    grant_valid == (state_q == GRANT));

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed bench for rr_grant_encoder (N=2) chained into the one-hot decoder.
module tb_rr_grant_encoder;

  localparam int N = 2;
  localparam int R = 2**N;

  logic         clk;
  logic         reset;
  logic [R-1:0] req;
  logic         ack;
  logic [N-1:0] grant_idx;
  logic         grant_valid;
  logic [R-1:0] dec;

  int checks;
  int passes;

  typedef struct {
    logic [R-1:0] req;
    logic         ack;
    logic         exp_vld;
    logic [N-1:0] exp_idx;
    logic [N-1:0] exp_ptr;
  } vec_t;

  vec_t vecs[$];

  rr_grant_encoder #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .ack         (ack),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  onehot_decoder #(.N(N)) u_dec (
    .sel (grant_idx),
    .dec (dec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [R-1:0] r, input logic a, input logic v,
                     input logic [N-1:0] i, input logic [N-1:0] p);
    vec_t t;
    t.req = r; t.ack = a; t.exp_vld = v; t.exp_idx = i; t.exp_ptr = p;
    vecs.push_back(t);
  endtask

  initial begin
    logic [R-1:0] exp_dec;
    checks = 0;
    passes = 0;
    req    = '0;
    ack    = 1'b0;
    reset  = 1'b1;
    #1;
    chk("reset_vld", int'(grant_valid), 0);
    chk("reset_idx", int'(grant_idx), 0);
    step();
    reset = 1'b0;

    // Single requester, held 5 more cycles without ack, then ack wraps ptr to 0.
    add(4'b1000, 0, 1, 3, 0);
    for (int k = 0; k < 5; k++) add(4'b1000, 0, 1, 3, 0);
    add(4'b1000, 1, 0, 3, 0);
    add(4'b0000, 0, 0, 3, 0);
    add(4'b0000, 1, 0, 3, 0);
    // Rotation with ack every cycle: 0,1,2,3,0,1.
    add(4'b1111, 1, 1, 0, 0);
    add(4'b1111, 1, 1, 1, 1);
    add(4'b1111, 1, 1, 2, 2);
    add(4'b1111, 1, 1, 3, 3);
    add(4'b1111, 1, 1, 0, 0);
    add(4'b1111, 1, 1, 1, 1);
    // Hold idx 2 while a different request appears, then move on after ack.
    add(4'b0100, 1, 1, 2, 2);
    add(4'b0001, 0, 1, 2, 2);
    add(4'b0001, 0, 1, 2, 2);
    add(4'b0001, 1, 1, 0, 3);
    // Self-exclusion: lone requester loses one cycle after its ack.
    add(4'b0010, 1, 1, 1, 1);
    add(4'b0010, 1, 0, 1, 2);
    add(4'b0010, 0, 1, 1, 2);
    add(4'b0000, 1, 0, 1, 2);

    foreach (vecs[n]) begin
      req = vecs[n].req;
      ack = vecs[n].ack;
      step();
      chk($sformatf("vec%0d_vld", n), int'(grant_valid), int'(vecs[n].exp_vld));
      chk($sformatf("vec%0d_idx", n), int'(grant_idx), int'(vecs[n].exp_idx));
      chk($sformatf("vec%0d_ptr", n), int'(dut.ptr_q), int'(vecs[n].exp_ptr));
      if (vecs[n].exp_vld) begin
        exp_dec = 4'b0001 << vecs[n].exp_idx;
        chk($sformatf("vec%0d_dec", n), int'(dec), int'(exp_dec));
      end
    end

    // Reset asserted mid-GRANT with idx 2 takes effect without a clock edge.
    req = 4'b0100;
    ack = 1'b0;
    step();
    chk("pre_rst_vld", int'(grant_valid), 1);
    chk("pre_rst_idx", int'(grant_idx), 2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_vld", int'(grant_valid), 0);
    chk("async_rst_idx", int'(grant_idx), 0);
    chk("async_rst_ptr", int'(dut.ptr_q), 0);
    step();
    chk("held_rst_vld", int'(grant_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("post_rst_vld", int'(grant_valid), 1);
    chk("post_rst_idx", int'(grant_idx), 2);
    chk("post_rst_dec", int'(dec), 4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rr_grant_encoder.md
# rr_grant_encoder

Round-robin arbiter that selects one of 2**N requesters and presents the winner as a registered N-bit binary index with a valid/ack handshake. It sits directly upstream of the N-to-2**N one-hot decoder: `grant_idx` drives the decoder's select input, and the decoder's one-hot output becomes the grant vector seen by the requesters. Fairness comes from a rotating priority pointer that advances past each acknowledged winner.

## Interface
- `N`, default 3: index width; requester count R = 2**N.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `req` input 2**N: level request per requester; bit i requests slot i.
- `ack` input 1: consumer has accepted the current grant; sampled only while `grant_valid`=1.
- `grant_idx` output N: registered binary index of the current winner; feeds the decoder select.
- `grant_valid` output 1: registered; `grant_idx` holds a live grant.

## Operation
- State machine with states IDLE and GRANT (`state_t`).
- Rotating pointer `ptr` (N bits) is the highest-priority slot. Priority order is ptr, ptr+1, …, ptr+R-1, modulo R.
- Pick function: the first set bit of `req` scanning from `ptr` upward with wrap. It produces `pick_idx` and `pick_any`.
- **IDLE:**
  - If `pick_any`=0, stay in IDLE with outputs unchanged.
  - If `pick_any`=1, register `grant_idx`←`pick_idx`, `grant_valid`←1, and go to GRANT.
- **GRANT:** `grant_idx` is frozen until `ack`, even if `req[grant_idx]` drops or a higher-priority request arrives.
- **ack in GRANT:** `ptr`←`grant_idx`+1 (wraps R-1→0). The next winner is picked with this updated pointer and the current `req`, excluding bit `grant_idx` for this one decision.
  - If there is a winner, stay in GRANT, load the new `grant_idx`, and keep `grant_valid`=1 (back-to-back grants).
  - If there is no winner, `grant_valid`←0 and go to IDLE. `grant_idx` keeps its last value.
- `ack` while in IDLE is ignored.
- Width rules:
  - Pointer and index arithmetic are N-bit unsigned with natural wrap.
  - The rotate in the pick function uses a 2R-bit concatenation of `req` with itself.
  - No X propagation is allowed when `req`=0.
- **Reset (including mid-GRANT):** state=IDLE, `ptr`=0, `grant_idx`=0, `grant_valid`=0. An outstanding grant is dropped and no ack is owed.

## Timing
- Latency from request to grant is 1 cycle: `req` sampled at edge k gives `grant_valid`=1 after edge k.
- Latency from `ack` to the next grant is 1 cycle: `ack` sampled at edge k gives the new `grant_idx` after edge k, with no bubble.
- All outputs are flops. There is no combinational path from `req` or `ack` to any output.
- Reset is asynchronous on assertion. Deassertion is assumed synchronous to `clk` and is handled outside this block.
- Maximum throughput is one grant per cycle, reached when `ack` is held at 1 and requests stay pending.

## Structure
- Package `rr_pkg`:
  - `typedef enum logic {IDLE, GRANT} state_t`.
  - Default index width constant `RR_N = 3`.
- Sub-module `rr_pick #(N)`: purely combinational.
  - Inputs: `req`, `ptr`, `mask_idx`, `mask_en`.
  - Outputs: `pick_idx`, `pick_any`.
  - `rr_grant_encoder` is the FSM plus `ptr`/output registers around one `rr_pick` instance.
- The top-level bench instantiates `rr_grant_encoder` feeding the existing decoder, and checks that the decoder output equals the expected one-hot grant whenever `grant_valid`=1.

## Test plan
All scenarios use N=2 (R=4).
- **Reset values:** assert `reset` mid-GRANT with `grant_idx`=2. Required: immediately `grant_valid`=0 and `grant_idx`=0; after release, `req`=4'b0100 is granted with idx 2 one cycle later.
- **Single requester:** `req`=4'b1000 from reset. Required: after one edge `grant_idx`=3 and `grant_valid`=1. Idx 3 is held for 5 cycles without `ack`. After `ack`, `grant_valid`=0 and `ptr`=0 (wrap).
- **Rotation fairness:** `req`=4'b1111 held, `ack`=1 every cycle. Required grant sequence is 0,1,2,3,0,1 on consecutive cycles with `grant_valid` never dropping.
- **Hold under priority change:** idx 2 granted, then `req` becomes 4'b0001 before `ack`. Required: `grant_idx` stays 2 until `ack`, then idx 0 is granted the next cycle.
- **Self-exclusion:** `req`=4'b0010 only, grant idx 1, `ack` with `req` still 4'b0010. Required: `grant_valid`=0 for one cycle, then idx 1 is re-granted.
- **Decoder chain:** with grants cycling 0..3, the decoder output is 0001, 0010, 0100, 1000 respectively.
